enemy_wave_ctrl: RTL and testbench
==================================

# enemy_wave_ctrl

Parametrised game-logic core that replaces the fixed three-enemy arrangement with N_ENEMY independent enemy lanes. It schedules spawns round-robin, advances enemies toward their bases, resolves cursor rocket hits, latches nuked bases and counts kills. It sits between the cursor/click input path and the vector renderer, on the 100 MHz game clock.

## Interface
- N_ENEMY, 4: number of enemy lanes (1..8)
- OUT_WIDTH, 8: coordinate and killcount width
- ADDRESSWIDTH, 16: sprite address width
- ADR_START, 0: sprite address of a flying enemy
- ADR_DESTROY, 64: sprite address shown during destroy animation
- X_START, 0: spawn x coordinate
- X_END, 200: x at which the lane's base is nuked (X_END > X_START)
- LANE_Y0, 40: y of lane 0; LANE_STEP, 30: y increment per lane
- SPEED_TICKS, 30_000_000: clocks per 1-pixel step
- SPAWN_TICKS, 10_000_000: clocks between spawn attempts
- DESTROY_TIME, 100_000_000: destroy-animation clocks
- XY_PRECISION, 10: hit window half-width in pixels
- clk100MHz  in  1  game clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- xcursor, ycursor  in  OUT_WIDTH each  cursor position
- click  in  1  fire button level (already synchronised)
- xenemy, yenemy  out  N_ENEMY*OUT_WIDTH each  packed lane coordinates, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- spawn  out  N_ENEMY  lane visible (FLYING or DESTROY)
- adr_enemy  out  N_ENEMY*ADDRESSWIDTH  packed sprite addresses
- base_nuked  out  N_ENEMY  sticky per-lane nuke flag
- killcount  out  OUT_WIDTH  saturating kill counter
- game_over  out  1  all bases nuked

## Operation
- Per-lane FSM: IDLE -> FLYING (spawn grant) -> DESTROY (hit) -> IDLE after DESTROY_TIME clocks; FLYING -> IDLE when base reached.
- y per lane constant: LANE_Y0 + i*LANE_STEP, truncated to OUT_WIDTH.
- Speed counter 0..SPEED_TICKS-1, tick on terminal count, shared by all lanes; on tick every FLYING lane x += 1.
- Base reached: FLYING lane with x == X_END on a tick -> IDLE, base_nuked[i] set, x reloaded to X_START.
- Spawn counter 0..SPAWN_TICKS-1; on terminal count grant the first lane, searching from rr_ptr upward with wrap, that is IDLE and not nuked; rr_ptr moves to granted+1 mod N_ENEMY. No eligible lane: attempt dropped, rr_ptr unchanged.
- Fire: edge = click & ~click_q. Hit on lane i if FLYING and |x-xcursor| <= XY_PRECISION and |y-ycursor| <= XY_PRECISION (unsigned differences, no wrap). Lowest-index hit lane only -> DESTROY, killcount += 1, saturating at 2^OUT_WIDTH-1. No hit: no effect.
- DESTROY: adr = ADR_DESTROY, x frozen, does not move; on expiry x = X_START, adr = ADR_START.
- Nuked lanes never respawn; game_over = &base_nuked, registered; spawn grants stop once game_over is 1.
- Hit and base-reach in same cycle: hit wins, base not nuked.
- Spawn grant and hit on different lanes in same cycle: both taken.

## Timing
- All outputs registered; reset values: x = X_START, y = lane y, spawn = 0, adr = ADR_START, base_nuked = 0, killcount = 0, game_over = 0, counters and rr_ptr = 0, click_q = 0.
- Edge detected in cycle t -> DESTROY, adr and killcount visible after edge t+1.
- Tick in cycle t -> new x visible after edge t+1.
- game_over asserts one clock after final base_nuked bit.
- Reset mid-operation: everything returns to reset values on the next edge, including sticky flags.
- click held high: exactly one fire event per rising edge.

## Configuration
- MULTI_KILL_EN defined: a click destroys every lane in the hit window; killcount += popcount of hits, saturating.
- Undefined: lowest-index hit lane only, increment of 1.

## Test plan
- Params N_ENEMY=4, SPEED_TICKS=2, SPAWN_TICKS=4, DESTROY_TIME=3, X_END=20: release rst -> lane 0 spawn after 4 clocks, lanes 1,2,3 at 4-clock intervals, x steps every 2 clocks.
- Cursor at (x0, 40), click 0->1 -> lane 0 DESTROY, adr = ADR_DESTROY, killcount 1; after 3 clocks spawn[0] = 0, x = X_START.
- Two lanes in window, one click -> only lower lane killed, killcount +1 (macro off); both killed, +2 (MULTI_KILL_EN).
- Let all lanes reach X_END -> base_nuked = 4'b1111, game_over next clock, no further spawns.
- Hit coinciding with x == X_END tick -> DESTROY, base_nuked bit stays 0.
- killcount forced to 255 then another hit -> stays 255; rst mid-flight -> all outputs reset values next clock.

Source files
------------

// File: rtl/enemy_wave_if.sv
// Cursor/fire inputs and per-lane enemy outputs of enemy_wave_ctrl.
// Lane i occupies [i*OUT_WIDTH +: OUT_WIDTH] / [i*ADDRESSWIDTH +: ADDRESSWIDTH].
interface enemy_wave_if #(
  parameter int N_ENEMY      = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 16
);
  // No valid/ready pair: click is a level, and each 0->1 step of it is one fire event;
  // every output is a registered status word that is valid on every cycle.
  logic [OUT_WIDTH-1:0]              xcursor;
  logic [OUT_WIDTH-1:0]              ycursor;
  logic                              click;
  logic [N_ENEMY*OUT_WIDTH-1:0]      xenemy;
  logic [N_ENEMY*OUT_WIDTH-1:0]      yenemy;
  logic [N_ENEMY-1:0]                spawn;
  logic [N_ENEMY*ADDRESSWIDTH-1:0]   adr_enemy;
  logic [N_ENEMY-1:0]                base_nuked;
  logic [OUT_WIDTH-1:0]              killcount;
  logic                              game_over;
  logic [2*N_ENEMY-1:0]              lane_state;

  modport master (
    output xcursor, ycursor, click,
    input  xenemy, yenemy, spawn, adr_enemy, base_nuked, killcount, game_over, lane_state
  );

  modport slave (
    input  xcursor, ycursor, click,
    output xenemy, yenemy, spawn, adr_enemy, base_nuked, killcount, game_over, lane_state
  );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// N-lane enemy wave controller: round-robin spawns, shared speed tick, cursor hits, nukes, kills.
// Optional MULTI_KILL_EN: one click destroys every lane inside the hit window.
module enemy_wave_ctrl #(
  parameter int N_ENEMY      = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 16,
  parameter int ADR_START    = 0,
  parameter int ADR_DESTROY  = 64,
  parameter int X_START      = 0,
  parameter int X_END        = 200,
  parameter int LANE_Y0      = 40,
  parameter int LANE_STEP    = 30,
  parameter int SPEED_TICKS  = 30_000_000,
  parameter int SPAWN_TICKS  = 10_000_000,
  parameter int DESTROY_TIME = 100_000_000,
  parameter int XY_PRECISION = 10
) (
  input logic        clk100MHz,
  input logic        rst,
  enemy_wave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    DESTROY = 2'd2
  } lane_state_t;

  localparam int SPD_W = (SPEED_TICKS  > 1) ? $clog2(SPEED_TICKS)  : 1;
  localparam int SPN_W = (SPAWN_TICKS  > 1) ? $clog2(SPAWN_TICKS)  : 1;
  localparam int DST_W = (DESTROY_TIME > 1) ? $clog2(DESTROY_TIME) : 1;
  localparam int PTR_W = (N_ENEMY      > 1) ? $clog2(N_ENEMY)      : 1;
  localparam int KW    = OUT_WIDTH + 4;

  localparam logic [SPD_W-1:0]        SPD_LAST  = SPD_W'(SPEED_TICKS - 1);
  localparam logic [SPN_W-1:0]        SPN_LAST  = SPN_W'(SPAWN_TICKS - 1);
  localparam logic [DST_W-1:0]        DST_LAST  = DST_W'(DESTROY_TIME - 1);
  localparam logic [PTR_W-1:0]        PTR_LAST  = PTR_W'(N_ENEMY - 1);
  localparam logic [OUT_WIDTH-1:0]    X_START_C = OUT_WIDTH'(X_START);
  localparam logic [OUT_WIDTH-1:0]    X_END_C   = OUT_WIDTH'(X_END);
  localparam logic [OUT_WIDTH-1:0]    PREC      = OUT_WIDTH'(XY_PRECISION);
  localparam logic [ADDRESSWIDTH-1:0] ADR_FLY   = ADDRESSWIDTH'(ADR_START);
  localparam logic [ADDRESSWIDTH-1:0] ADR_DEAD  = ADDRESSWIDTH'(ADR_DESTROY);
  localparam logic [KW-1:0]           KILL_MAX  = {4'b0, {OUT_WIDTH{1'b1}}};

  function automatic logic [OUT_WIDTH-1:0] lane_y(input int i);
    return OUT_WIDTH'(LANE_Y0 + i * LANE_STEP);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] abs_diff(input logic [OUT_WIDTH-1:0] a,
                                                    input logic [OUT_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  lane_state_t                     state   [N_ENEMY];
  logic [OUT_WIDTH-1:0]            x_q     [N_ENEMY];
  logic [DST_W-1:0]                dst_cnt [N_ENEMY];
  logic [SPD_W-1:0]                spd_cnt;
  logic [SPN_W-1:0]                spn_cnt;
  logic [PTR_W-1:0]                rr_ptr;
  logic                            click_q;
  logic [N_ENEMY-1:0]              spawn_q;
  logic [N_ENEMY-1:0]              nuked_q;
  logic [OUT_WIDTH-1:0]            kill_q;
  logic                            over_q;
  logic [N_ENEMY*ADDRESSWIDTH-1:0] adr_q;

  logic                            fire;
  logic                            tick;
  logic                            spawn_try;
  logic [N_ENEMY-1:0]              hit;
  logic [N_ENEMY-1:0]              kill;
  logic [3:0]                      kill_inc;
  logic [KW-1:0]                   kill_sum;
  logic [OUT_WIDTH-1:0]            kill_next;
  logic [N_ENEMY-1:0]              grant;
  logic                            found;
  logic [PTR_W-1:0]                grant_idx;
  logic [PTR_W-1:0]                rr_next;
  int                              scan_idx;

  // Hit detection and kill accounting, all from the current registered lane state.
  always_comb begin
    fire      = bus.click & ~click_q;
    tick      = (spd_cnt == SPD_LAST);
    spawn_try = (spn_cnt == SPN_LAST) && !over_q;
    hit       = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      hit[i] = fire && (state[i] == FLYING)
               && (abs_diff(x_q[i], bus.xcursor) <= PREC)
               && (abs_diff(lane_y(i), bus.ycursor) <= PREC);
    end
`ifdef MULTI_KILL_EN
    kill = hit;
`else
    kill = hit & (~hit + N_ENEMY'(1));
`endif
    kill_inc = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      kill_inc = kill_inc + {3'b000, kill[i]};
    end
    kill_sum  = {4'b0, kill_q} + {{OUT_WIDTH{1'b0}}, kill_inc};
    kill_next = (kill_sum > KILL_MAX) ? {OUT_WIDTH{1'b1}} : kill_sum[OUT_WIDTH-1:0];
  end

  // Round-robin spawn search starting at rr_ptr; nuked lanes are never eligible.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = 0;
    for (int k = 0; k < N_ENEMY; k++) begin
      scan_idx = (int'(rr_ptr) + k) % N_ENEMY;
      if (spawn_try && !found && (state[scan_idx] == IDLE) && !nuked_q[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = PTR_W'(scan_idx);
      end
    end
    rr_next = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        state[i]   <= IDLE;
        x_q[i]     <= X_START_C;
        dst_cnt[i] <= '0;
      end
      spd_cnt <= '0;
      spn_cnt <= '0;
      rr_ptr  <= '0;
      click_q <= 1'b0;
      spawn_q <= '0;
      nuked_q <= '0;
      kill_q  <= '0;
      over_q  <= 1'b0;
      adr_q   <= {N_ENEMY{ADR_FLY}};
    end else begin
      click_q <= bus.click;
      spd_cnt <= tick ? '0 : spd_cnt + SPD_W'(1);
      spn_cnt <= (spn_cnt == SPN_LAST) ? '0 : spn_cnt + SPN_W'(1);
      if (found) rr_ptr <= rr_next;
      kill_q  <= kill_next;
      over_q  <= &nuked_q;
      for (int i = 0; i < N_ENEMY; i++) begin
        case (state[i])
          IDLE: begin
            if (grant[i]) begin
              state[i]   <= FLYING;
              x_q[i]     <= X_START_C;
              spawn_q[i] <= 1'b1;
            end
          end
          FLYING: begin
            // A hit outranks reaching the base on the same tick.
            if (kill[i]) begin
              state[i]   <= DESTROY;
              dst_cnt[i] <= '0;
              adr_q[i*ADDRESSWIDTH +: ADDRESSWIDTH] <= ADR_DEAD;
            end else if (tick) begin
              if (x_q[i] == X_END_C) begin
                state[i]   <= IDLE;
                nuked_q[i] <= 1'b1;
                x_q[i]     <= X_START_C;
                spawn_q[i] <= 1'b0;
              end else begin
                x_q[i] <= x_q[i] + OUT_WIDTH'(1);
              end
            end
          end
          DESTROY: begin
            if (dst_cnt[i] == DST_LAST) begin
              state[i]   <= IDLE;
              x_q[i]     <= X_START_C;
              spawn_q[i] <= 1'b0;
              adr_q[i*ADDRESSWIDTH +: ADDRESSWIDTH] <= ADR_FLY;
            end else begin
              dst_cnt[i] <= dst_cnt[i] + DST_W'(1);
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.xenemy     = '0;
    bus.yenemy     = '0;
    bus.lane_state = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      bus.xenemy[i*OUT_WIDTH +: OUT_WIDTH] = x_q[i];
      bus.yenemy[i*OUT_WIDTH +: OUT_WIDTH] = lane_y(i);
      bus.lane_state[2*i +: 2]             = state[i];
    end
    bus.spawn      = spawn_q;
    bus.adr_enemy  = adr_q;
    bus.base_nuked = nuked_q;
    bus.killcount  = kill_q;
    bus.game_over  = over_q;
  end

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Bench for enemy_wave_ctrl: lane-level reference model compared every cycle plus pinned literals.
`timescale 1ns/1ps
module tb_enemy_wave_ctrl;
  localparam int N = 4, OW = 8, AW = 16;
  localparam int ADR_S = 0, ADR_D = 64, XS = 0, XE = 20, LY0 = 40, LST = 15;
  localparam int SPT = 2, SWT = 4, DT = 3, PREC = 10, KMAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_wave_if #(.N_ENEMY(N), .OUT_WIDTH(OW), .ADDRESSWIDTH(AW)) bus ();

  enemy_wave_ctrl #(
    .N_ENEMY(N), .OUT_WIDTH(OW), .ADDRESSWIDTH(AW), .ADR_START(ADR_S), .ADR_DESTROY(ADR_D),
    .X_START(XS), .X_END(XE), .LANE_Y0(LY0), .LANE_STEP(LST), .SPEED_TICKS(SPT),
    .SPAWN_TICKS(SWT), .DESTROY_TIME(DT), .XY_PRECISION(PREC)
  ) dut (
    .clk100MHz(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired at %0t", name, $time);
  endtask

  function automatic int lane_y(input int i);
    return (LY0 + i * LST) % 256;
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference model: each lane is "flying", "dying" (with clocks left) or neither.
  bit m_valid = 1'b0;
  bit m_fly[N], m_dying[N], m_nuked[N];
  int m_x[N], m_left[N];
  int m_kills, m_rr, m_cyc;
  bit m_go, m_prev_click;

  function automatic bit all_nuked();
    bit a = 1'b1;
    for (int i = 0; i < N; i++) a &= m_nuked[i];
    return a;
  endfunction

  always @(posedge clk) begin
    bit fire, tick, try_spawn, granted, o_go;
    bit o_fly[N], o_dying[N], o_nuked[N], vict[N];
    int nv, j;
    if (rst) begin
      m_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_fly[i] = 0; m_dying[i] = 0; m_nuked[i] = 0; m_x[i] = XS; m_left[i] = 0;
      end
      m_kills = 0; m_rr = 0; m_cyc = 0; m_go = 0; m_prev_click = 0;
    end else if (m_valid) begin
      fire = bus.click && !m_prev_click;
      m_prev_click = bus.click;
      tick = (m_cyc % SPT) == SPT - 1;
      try_spawn = (m_cyc % SWT) == SWT - 1;
      m_cyc++;
      o_go = m_go;
      for (int i = 0; i < N; i++) begin
        o_fly[i] = m_fly[i]; o_dying[i] = m_dying[i]; o_nuked[i] = m_nuked[i]; vict[i] = 0;
      end
      nv = 0;
      for (int i = 0; i < N; i++) begin
        if (fire && o_fly[i] && absd(m_x[i], int'(bus.xcursor)) <= PREC
            && absd(lane_y(i), int'(bus.ycursor)) <= PREC) begin
`ifdef MULTI_KILL_EN
          vict[i] = 1; nv++;
`else
          if (nv == 0) begin vict[i] = 1; nv = 1; end
`endif
        end
      end
      for (int i = 0; i < N; i++) begin
        if (o_dying[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_dying[i] = 0; m_x[i] = XS; end
        end else if (o_fly[i]) begin
          if (vict[i]) begin
            m_fly[i] = 0; m_dying[i] = 1; m_left[i] = DT;
          end else if (tick) begin
            if (m_x[i] == XE) begin m_fly[i] = 0; m_nuked[i] = 1; m_x[i] = XS; end
            else m_x[i]++;
          end
        end
      end
      granted = 0;
      if (try_spawn && !o_go) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!granted && !o_fly[j] && !o_dying[j] && !o_nuked[j]) begin
            granted = 1; m_fly[j] = 1; m_x[j] = XS; m_rr = (j + 1) % N;
          end
        end
      end
      m_kills = (m_kills + nv > KMAX) ? KMAX : m_kills + nv;
      m_go = all_nuked() && 1'b1 ? (o_nuked[0] & o_nuked[1] & o_nuked[2] & o_nuked[3]) : 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        check("x_lane", 64'(bus.xenemy[i*OW +: OW]), 64'(m_x[i]));
        check("y_lane", 64'(bus.yenemy[i*OW +: OW]), 64'(lane_y(i)));
        check("spawn_lane", 64'(bus.spawn[i]), 64'(m_fly[i] | m_dying[i]));
        check("adr_lane", 64'(bus.adr_enemy[i*AW +: AW]), 64'(m_dying[i] ? ADR_D : ADR_S));
        check("nuked_lane", 64'(bus.base_nuked[i]), 64'(m_nuked[i]));
      end
      check("killcount", 64'(bus.killcount), 64'(m_kills));
      check("game_over", 64'(bus.game_over), 64'(m_go));
    end
  end

  task automatic reset_literals(input string tag);
    check({tag, "_spawn"}, 64'(bus.spawn), 64'h0);
    check({tag, "_x"}, 64'(bus.xenemy), 64'h0);
    check({tag, "_y"}, 64'(bus.yenemy), 64'h5546_3728);
    check({tag, "_adr"}, 64'(bus.adr_enemy), 64'h0);
    check({tag, "_nuked"}, 64'(bus.base_nuked), 64'h0);
    check({tag, "_kills"}, 64'(bus.killcount), 64'h0);
    check({tag, "_over"}, 64'(bus.game_over), 64'h0);
  endtask

  task automatic wait_fly(output int lane);
    int n = 0;
    lane = -1;
    while (lane < 0 && n < 100) begin
      for (int i = N - 1; i >= 0; i--) if (m_fly[i]) lane = i;
      if (lane < 0) begin @(negedge clk); n++; end
    end
    if (lane < 0) begin timeout_fail("wait_fly"); lane = 0; end
  endtask

  task automatic kill_lane(input int lane);
    bus.xcursor = OW'(m_x[lane]);
    bus.ycursor = OW'(lane_y(lane));
    bus.click = 1'b1;
    @(negedge clk);
    bus.click = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, n;
    rst = 1'b1;
    bus.xcursor = '0;
    bus.ycursor = '0;
    bus.click = 1'b0;
    repeat (3) @(negedge clk);
    reset_literals("reset");
    rst = 1'b0;

    // Lane 0 granted on the 4th edge, lane 1 on the 8th; ticks on even edges.
    repeat (4) @(negedge clk);
    check("first_spawn", 64'(bus.spawn), 64'b0001);
    repeat (4) @(negedge clk);
    check("second_spawn", 64'(bus.spawn), 64'b0011);
    check("lane0_x_after_2_ticks", 64'(bus.xenemy[7:0]), 64'd2);

    // Single kill on lane 0, click held two extra clocks.
    bus.xcursor = 8'd2; bus.ycursor = 8'd40; bus.click = 1'b1;
    @(negedge clk);
    check("kill1_count", 64'(bus.killcount), 64'd1);
    check("kill1_adr", 64'(bus.adr_enemy[15:0]), 64'd64);
    repeat (2) @(negedge clk);
    bus.click = 1'b0;
    @(negedge clk);
    check("destroy_end_spawn0", 64'(bus.spawn[0]), 64'd0);
    check("destroy_end_x0", 64'(bus.xenemy[7:0]), 64'd0);
    check("held_click_count", 64'(bus.killcount), 64'd1);

    // Lanes 1 and 2 both inside a window centred at y=62.
    n = 0;
    while (!(m_fly[1] && m_fly[2]) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) timeout_fail("wait_two_lanes");
    bus.xcursor = OW'(m_x[1]); bus.ycursor = 8'd62; bus.click = 1'b1;
    @(negedge clk);
    bus.click = 1'b0;
`ifdef MULTI_KILL_EN
    check("double_window_count", 64'(bus.killcount), 64'd3);
    check("double_window_lane2", 64'(bus.adr_enemy[47:32]), 64'd64);
`else
    check("double_window_count", 64'(bus.killcount), 64'd2);
    check("double_window_lane2", 64'(bus.adr_enemy[47:32]), 64'd0);
`endif
    check("double_window_lane1", 64'(bus.adr_enemy[31:16]), 64'd64);

    // Hit landing on the same tick that would nuke the base.
    tgt = -1; n = 0;
    while (tgt < 0 && n < 400) begin
      for (int i = N - 1; i >= 0; i--)
        if (m_fly[i] && m_x[i] == XE && (m_cyc % SPT) == SPT - 1) tgt = i;
      if (tgt < 0) begin @(negedge clk); n++; end
    end
    if (tgt < 0) begin timeout_fail("wait_base_tick"); tgt = 0; end
    kill_lane(tgt);
    check("hit_beats_base_nuked", 64'(bus.base_nuked[tgt]), 64'd0);
    check("hit_beats_base_adr", 64'(bus.adr_enemy[tgt*AW +: AW]), 64'd64);

    // Let every base fall.
    n = 0;
    while (!all_nuked() && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) timeout_fail("wait_all_nuked");
    check("all_nuked", 64'(bus.base_nuked), 64'b1111);
    check("game_over_lags", 64'(bus.game_over), 64'd0);
    @(negedge clk);
    check("game_over_set", 64'(bus.game_over), 64'd1);
    repeat (8) @(negedge clk);
    check("no_spawn_after_over", 64'(bus.spawn), 64'h0);

    // Reset clears sticky flags, then a mid-flight reset.
    rst = 1'b1;
    @(negedge clk);
    reset_literals("reset_after_over");
    rst = 1'b0;
    wait_fly(tgt);
    kill_lane(tgt);
    repeat (6) @(negedge clk);
    check("pre_reset_kills", 64'(bus.killcount), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_literals("reset_mid_flight");
    rst = 1'b0;

    // Drive the kill counter into saturation.
    n = 0;
    while (m_kills < KMAX && n < 400) begin
      wait_fly(tgt);
      kill_lane(tgt);
      @(negedge clk);
      n++;
    end
    check("kills_at_max", 64'(bus.killcount), 64'd255);
    wait_fly(tgt);
    kill_lane(tgt);
    check("kills_saturated", 64'(bus.killcount), 64'd255);
    check("saturated_hit_adr", 64'(bus.adr_enemy[tgt*AW +: AW]), 64'd64);
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
